// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared length codes and arbiter state encodings
package mem_arbiter_pkg;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - rr_pick: first set request at or after ptr, wrapping
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);

    int idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-channel memory arbiter, one outstanding bus transaction
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_PORT = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 2,
    parameter int RR     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PORT-1:0]        p_req,
    input  logic [N_PORT-1:0]        p_we,
    input  logic [N_PORT*ADDR_W-1:0] p_addr,
    input  logic [N_PORT*DATA_W-1:0] p_wdata,
    input  logic [N_PORT*LEN_W-1:0]  p_len,
    output logic [N_PORT*DATA_W-1:0] p_rdata,
    output logic [N_PORT-1:0]        p_ack,
    output logic                     m_req,
    output logic                     m_we,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [DATA_W-1:0]        m_wdata,
    output logic [LEN_W-1:0]         m_len,
    input  logic [DATA_W-1:0]        m_rdata,
    input  logic                     m_ack,
    output logic                     busy
);

    localparam int PTR_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;

    arb_state_t        state, state_next;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  grant;
    logic [PTR_W-1:0]  pick_ptr;
    logic [PTR_W-1:0]  win_idx;
    logic [N_PORT-1:0] win_oh;
    logic              win_valid;

    // Fixed-priority mode reuses the same picker starting from port 0.
    assign pick_ptr = (RR != 0) ? ptr : '0;

    rr_pick #(.N(N_PORT), .PTR_W(PTR_W)) u_pick (
        .req   (p_req),
        .ptr   (pick_ptr),
        .grant (win_oh),
        .valid (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_PORT; i++) begin
            if (win_oh[i]) win_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (win_valid) state_next = ST_BUSY;
            ST_BUSY: if (m_ack)     state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            grant   <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_len   <= '0;
            p_ack   <= '0;
            p_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        m_req   <= 1'b1;
                        m_we    <= p_we[win_idx];
                        m_addr  <= p_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                        m_wdata <= p_wdata[int'(win_idx)*DATA_W +: DATA_W];
                        m_len   <= p_len[int'(win_idx)*LEN_W +: LEN_W];
                        grant   <= win_idx;
                    end
                end
                ST_BUSY: begin
                    if (m_ack) begin
                        m_req        <= 1'b0;
                        p_ack[grant] <= 1'b1;
                        if (!m_we) p_rdata[int'(grant)*DATA_W +: DATA_W] <= m_rdata;
                    end
                end
                ST_RESP: begin
                    p_ack <= '0;
                    if (RR != 0)
                        ptr <= (grant == PTR_W'(N_PORT-1)) ? '0 : grant + PTR_W'(1);
                end
                default: p_ack <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   p_req, p_we, p_ack;
    logic [127:0] p_addr, p_wdata, p_rdata;
    logic [7:0]   p_len;
    logic         m_req, m_we, m_ack, busy;
    logic [31:0]  m_addr, m_wdata, m_rdata;
    logic [1:0]   m_len;

    logic [3:0]   f_req, f_we, f_ack_p;
    logic [127:0] f_addr, f_wdata, f_rdata_p;
    logic [7:0]   f_len;
    logic         f_mreq, f_mwe, f_mack, f_busy;
    logic [31:0]  f_maddr, f_mwdata, f_mrdata;
    logic [1:0]   f_mlen;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.N_PORT(4), .ADDR_W(32), .DATA_W(32), .LEN_W(2), .RR(1)) dut (
        .clk(clk), .rst(rst), .p_req(p_req), .p_we(p_we), .p_addr(p_addr),
        .p_wdata(p_wdata), .p_len(p_len), .p_rdata(p_rdata), .p_ack(p_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_len(m_len), .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy)
    );

    mem_arbiter #(.N_PORT(4), .ADDR_W(32), .DATA_W(32), .LEN_W(2), .RR(0)) dut_fp (
        .clk(clk), .rst(rst), .p_req(f_req), .p_we(f_we), .p_addr(f_addr),
        .p_wdata(f_wdata), .p_len(f_len), .p_rdata(f_rdata_p), .p_ack(f_ack_p),
        .m_req(f_mreq), .m_we(f_mwe), .m_addr(f_maddr), .m_wdata(f_mwdata),
        .m_len(f_mlen), .m_rdata(f_mrdata), .m_ack(f_mack), .busy(f_busy)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    int ack_port[$];
    int ack_cyc[$];
    int cnt1, cnt3;

    initial begin
        rst = 1'b1;
        p_req = '0; p_we = '0; p_addr = '0; p_wdata = '0; p_len = '0;
        m_ack = 1'b0; m_rdata = '0;
        f_req = '0; f_we = '0; f_addr = '0; f_wdata = '0; f_len = '0;
        f_mack = 1'b0; f_mrdata = '0;

        repeat (2) @(negedge clk);
        chk("reset_m_req", m_req, 0);
        chk("reset_busy", busy, 0);
        chk("reset_p_ack", p_ack, 0);
        chk("reset_p_rdata", p_rdata[95:0], 0);
        chk("reset_m_addr", m_addr, 0);
        chk("reset_fp_busy", f_busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // single read from port 0, ack on the second BUSY cycle
        p_addr[31:0] = 32'h100;
        p_req = 4'b0001;
        @(negedge clk);
        chk("read_m_req", m_req, 1);
        chk("read_m_addr", m_addr, 32'h100);
        chk("read_m_we", m_we, 0);
        chk("read_busy", busy, 1);
        @(negedge clk);
        chk("read_no_early_ack", p_ack, 0);
        m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("read_p_ack", p_ack, 4'b0001);
        chk("read_rdata0", p_rdata[31:0], 32'hDEADBEEF);
        chk("read_rdata_hi", p_rdata[127:32], 0);
        chk("read_m_req_drop", m_req, 0);
        m_ack = 1'b0; m_rdata = '0; p_req = '0;
        @(negedge clk);
        chk("read_ack_pulse", p_ack, 0);
        chk("read_idle", busy, 0);
        chk("read_rdata_hold", p_rdata[31:0], 32'hDEADBEEF);

        // stray bus ack in IDLE
        m_ack = 1'b1;
        @(negedge clk);
        chk("stray_p_ack", p_ack, 0);
        chk("stray_busy", busy, 0);
        chk("stray_m_req", m_req, 0);
        m_ack = 1'b0;

        // write from port 1; another port's request must not disturb BUSY
        p_we = 4'b0010;
        p_addr[63:32] = 32'h2004;
        p_wdata[63:32] = 32'h12345678;
        p_len[3:2] = LEN_WORD;
        p_req = 4'b0010;
        @(negedge clk);
        chk("wr_m_we", m_we, 1);
        chk("wr_m_addr", m_addr, 32'h2004);
        chk("wr_m_wdata", m_wdata, 32'h12345678);
        chk("wr_m_len", m_len, 2);
        p_req = 4'b0110;
        p_addr[95:64] = 32'hBAD0;
        @(negedge clk);
        chk("wr_hold_addr", m_addr, 32'h2004);
        chk("wr_hold_wdata", m_wdata, 32'h12345678);
        chk("wr_hold_we", m_we, 1);
        chk("wr_hold_len", m_len, 2);
        m_ack = 1'b1; m_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("wr_p_ack", p_ack, 4'b0010);
        chk("wr_rdata1_unchanged", p_rdata[63:32], 0);
        chk("wr_rdata0_unchanged", p_rdata[31:0], 32'hDEADBEEF);
        m_ack = 1'b0; m_rdata = '0; p_req = '0; p_we = '0;
        @(negedge clk);
        chk("wr_idle", busy, 0);

        // reset in the middle of BUSY (pointer is 2 here)
        p_req = 4'b0100;
        @(negedge clk);
        chk("rst_pre_m_req", m_req, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_m_req", m_req, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_p_ack", p_ack, 0);
        p_req = '0;
        @(negedge clk);
        chk("rst_no_p_ack", p_ack, 0);
        rst = 1'b0;

        // round-robin contention: grants must restart at port 0
        p_addr = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
        p_req = 4'b1111;
        m_ack = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (p_ack != 0) begin
                chk("rr_onehot", $onehot(p_ack), 1);
                ack_port.push_back(oh_idx(p_ack));
                ack_cyc.push_back(c);
            end
        end
        chk("rr_ack_count_ge5", ack_port.size() >= 5, 1);
        for (int k = 0; k < 5 && k < ack_port.size(); k++) begin
            chk($sformatf("rr_order_%0d", k), ack_port[k], k % 4);
            if (k > 0) chk($sformatf("rr_spacing_%0d", k), ack_cyc[k] - ack_cyc[k-1], 3);
        end
        p_req = '0; m_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rr_end_idle", busy, 0);

        // fixed priority: port 1 always beats port 3
        f_req = 4'b1010;
        f_mack = 1'b1;
        cnt1 = 0; cnt3 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (f_ack_p[1]) cnt1++;
            if (f_ack_p[3]) cnt3++;
        end
        chk("fp_port1_acks", cnt1, 7);
        chk("fp_port3_acks", cnt3, 0);
        f_req = '0; f_mack = 1'b0;
        repeat (3) @(negedge clk);
        chk("fp_end_idle", f_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
